vga_capture: RTL and testbench

- VGA receive end: samples the 24-bit RGB pixel stream plus hsync/vsync/blank_n produced by the VGA controller and writes each visible pixel into a frame buffer.
- Frame buffer uses the same {h,v} concatenated address layout as the display-side video memory, so a captured frame can be read back pixel-for-pixel.
- Used for loopback checking of the display path and for frame grabbing in simulation.
- Also checks line length, line count and sync framing.

---
 rtl/vga_capture.sv | 176 +++++++++++++++++
 tb/tb_vga_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// VGA receive end: registers the incoming pixel stream, writes visible pixels into a
// {h,v}-addressed frame buffer and grades every completed frame's line/sync framing.
module vga_capture #(
    parameter int   HSIZE       = 640,
    parameter int   VSIZE       = 480,
    parameter int   HWIDTH      = $clog2(HSIZE),
    parameter int   VWIDTH      = $clog2(VSIZE),
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vga_hsync,
    input  logic                     vga_vsync,
    input  logic                     vga_blank_n,
    input  logic [7:0]               vga_r,
    input  logic [7:0]               vga_g,
    input  logic [7:0]               vga_b,
    output logic                     wr_en,
    output logic [HWIDTH+VWIDTH-1:0] wr_addr,
    output logic [23:0]              wr_data,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic                     line_err,
    output logic [15:0]              frame_cnt
);

    // Counters carry one extra bit so they can hold HSIZE/VSIZE themselves.
    localparam int HCW = HWIDTH + 1;
    localparam int VCW = VWIDTH + 1;

    typedef enum logic [1:0] {IDLE, WAIT_LINE, IN_LINE} state_t;

    logic        hs_s1_q, vs_s1_q, blank_s1_q, hs_prev_q, vs_prev_q;
    logic [23:0] rgb_s1_q;

    state_t                   state_q, state_d;
    logic [HCW-1:0]           h_cnt_q, h_cnt_d;
    logic [VCW-1:0]           v_cnt_q, v_cnt_d;
    logic                     extra_q, extra_d;
    logic                     wr_en_q, wr_en_d;
    logic [HWIDTH+VWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]              wr_data_q, wr_data_d;
    logic                     frame_done_q, frame_done_d;
    logic                     frame_ok_q, frame_ok_d;
    logic                     line_err_q, line_err_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;

    logic vs_assert, hs_assert, h_vis, v_vis;

    assign vs_assert = (vs_s1_q == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
    assign hs_assert = (hs_s1_q == SYNC_ACTIVE) && (hs_prev_q != SYNC_ACTIVE);
    assign h_vis     = h_cnt_q < HCW'(HSIZE);
    assign v_vis     = v_cnt_q < VCW'(VSIZE);

    always_comb begin
        state_d      = state_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        extra_d      = extra_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        line_err_d   = line_err_q;
        frame_cnt_d  = frame_cnt_q;

        if (state_q == IDLE) begin
            if (vs_assert) begin
                h_cnt_d    = '0;
                v_cnt_d    = '0;
                extra_d    = 1'b0;
                line_err_d = 1'b0;
                state_d    = WAIT_LINE;
            end
        end else if (vs_assert) begin
            // Frame boundary wins over any pixel in the same cycle; an open line is truncated.
            frame_done_d = 1'b1;
            frame_ok_d   = (v_cnt_q == VCW'(VSIZE)) && !line_err_q && !extra_q
                           && (state_q != IN_LINE);
            frame_cnt_d  = frame_cnt_q + 16'd1;
            h_cnt_d      = '0;
            v_cnt_d      = '0;
            extra_d      = 1'b0;
            line_err_d   = 1'b0;
            state_d      = WAIT_LINE;
        end else if (state_q == WAIT_LINE) begin
            if (blank_s1_q) begin
                if (v_vis) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {HWIDTH'(0), v_cnt_q[VWIDTH-1:0]};
                    wr_data_d = rgb_s1_q;
                end else begin
                    extra_d = 1'b1;
                end
                h_cnt_d = HCW'(1);
                state_d = IN_LINE;
            end
        end else begin
            if (hs_assert) begin
                line_err_d = 1'b1;
            end
            if (blank_s1_q) begin
                if (h_vis) begin
                    if (v_vis) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {h_cnt_q[HWIDTH-1:0], v_cnt_q[VWIDTH-1:0]};
                        wr_data_d = rgb_s1_q;
                    end
                    h_cnt_d = h_cnt_q + HCW'(1);
                end else begin
                    line_err_d = 1'b1;
                end
            end else begin
                if (h_cnt_q != HCW'(HSIZE)) begin
                    line_err_d = 1'b1;
                end
                if (v_vis) begin
                    v_cnt_d = v_cnt_q + VCW'(1);
                end
                h_cnt_d = '0;
                state_d = WAIT_LINE;
            end
        end
    end

    // Sync registers reset to the idle level so no edge is seen right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_q      <= ~SYNC_ACTIVE;
            vs_s1_q      <= ~SYNC_ACTIVE;
            hs_prev_q    <= ~SYNC_ACTIVE;
            vs_prev_q    <= ~SYNC_ACTIVE;
            blank_s1_q   <= 1'b0;
            rgb_s1_q     <= '0;
            state_q      <= IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            extra_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            line_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            hs_s1_q      <= vga_hsync;
            vs_s1_q      <= vga_vsync;
            hs_prev_q    <= hs_s1_q;
            vs_prev_q    <= vs_s1_q;
            blank_s1_q   <= vga_blank_n;
            rgb_s1_q     <= {vga_r, vga_g, vga_b};
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            extra_q      <= extra_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            line_err_q   <= line_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign line_err   = line_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a 4x3 frame: a line-level frame model predicts every write
// and frame result, and one compare process checks the outputs on every cycle.
module tb_vga_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_hsync, vga_vsync, vga_blank_n;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          frame_done, frame_ok, line_err;
    logic [15:0]   frame_cnt;

    vga_capture #(.HSIZE(H), .VSIZE(V), .SYNC_ACTIVE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_ok(frame_ok), .line_err(line_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [23:0] data; } wr_t;
    typedef struct { int cyc; bit ok; } fr_t;
    wr_t wq[$];
    fr_t fq[$];

    int  total = 0, bad = 0;
    bit  chk_en = 0;
    bit  armed = 0, cur_bad = 0, in_line = 0;
    int  cur_lines = 0, seed = 1, exp_rst_cyc = -1, dut_writes = 0;

    logic [AW-1:0] last_addr = '0;
    logic [23:0]   last_data = '0;
    int            exp_cnt = 0;
    bit            exp_ok = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r_i, input logic hs_i, input logic vs_i,
                                 input logic bl_i, input logic [23:0] d_i);
        @(negedge clk);
        rst = r_i; vga_hsync = hs_i; vga_vsync = vs_i; vga_blank_n = bl_i;
        {vga_r, vga_g, vga_b} = d_i;
    endtask

    function automatic logic [23:0] pix(input int l, input int p);
        return {8'(seed), 4'(l), 4'(p), 8'(seed * 13 + l * 5 + p)};
    endfunction

    // A pixel driven now reaches the write port two clocks later.
    task automatic push_pixel(input int l, input int p);
        wr_t w;
        if (!armed) return;
        in_line = 1;
        if (l < V && p < H) begin
            w.cyc = cyc + 2; w.addr = AW'(p * 4 + l); w.data = pix(l, p);
            wq.push_back(w);
        end
    endtask

    task automatic model_reset();
        while (wq.size() > 0 && wq[$].cyc > cyc) void'(wq.pop_back());
        while (fq.size() > 0 && fq[$].cyc > cyc) void'(fq.pop_back());
        exp_rst_cyc = cyc + 1;
        armed = 0; cur_lines = 0; cur_bad = 0; in_line = 0;
    endtask

    task automatic close_frame();
        fr_t f;
        if (armed) begin
            f.cyc = cyc + 2;
            f.ok  = !cur_bad && !in_line && (cur_lines == V);
            fq.push_back(f);
        end
        armed = 1; cur_lines = 0; cur_bad = 0; in_line = 0;
        seed++;
    endtask

    task automatic vsync_pulse(input bit with_pix);
        applyStimulus(0, 1, 0, with_pix, with_pix ? pix(cur_lines, 9) : 24'h0);
        close_frame();
        applyStimulus(0, 1, 0, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
    endtask

    task automatic send_line(input int len, input int hs_at, input int rst_at);
        for (int p = 0; p < len; p++) begin
            applyStimulus(p == rst_at, (p == hs_at) ? 1'b0 : 1'b1, 1'b1, 1'b1, pix(cur_lines, p));
            if (p == rst_at) model_reset();
            else push_pixel(cur_lines, p);
            if (rst_at >= 0 && p == rst_at + 1) begin
                checkOutput("rst_wr_en", wr_en, 0);
                checkOutput("rst_frame_cnt", frame_cnt, 0);
                checkOutput("rst_frame_ok", frame_ok, 0);
                checkOutput("rst_frame_done", frame_done, 0);
            end
        end
        applyStimulus(0, 1, 1, 0, '0);
        if (armed) begin
            cur_lines++;
            if (len != H || hs_at >= 0) cur_bad = 1;
        end
        in_line = 0;
        applyStimulus(0, 0, 1, 0, '0);
        applyStimulus(0, 1, 1, 0, '0);
    endtask

    task automatic send_partial(input int len);
        for (int p = 0; p < len; p++) begin
            applyStimulus(0, 1, 1, 1, pix(cur_lines, p));
            push_pixel(cur_lines, p);
        end
        vsync_pulse(1);
    endtask

    task automatic compare_cycle();
        bit exp_we, exp_fd;
        wr_t w;
        fr_t f;
        if (cyc == exp_rst_cyc) begin
            last_addr = '0; last_data = '0; exp_cnt = 0; exp_ok = 0;
            checkOutput("rst_line_err", line_err, 0);
        end
        exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
        checkOutput("wr_en", wr_en, exp_we);
        if (exp_we) begin
            w = wq.pop_front();
            last_addr = w.addr; last_data = w.data;
        end
        if (wr_en) dut_writes++;
        checkOutput("wr_addr", wr_addr, last_addr);
        checkOutput("wr_data", wr_data, last_data);
        exp_fd = (fq.size() > 0) && (fq[0].cyc == cyc);
        checkOutput("frame_done", frame_done, exp_fd);
        if (exp_fd) begin
            f = fq.pop_front();
            exp_cnt = (exp_cnt + 1) % 65536;
            exp_ok = f.ok;
        end
        checkOutput("frame_cnt", frame_cnt, exp_cnt);
        checkOutput("frame_ok", frame_ok, exp_ok);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) compare_cycle();
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time %0t, expected bench to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rst = 1; vga_hsync = 1; vga_vsync = 1; vga_blank_n = 0;
        {vga_r, vga_g, vga_b} = '0;
        repeat (3) applyStimulus(1, 1, 1, 0, '0);
        checkOutput("init_wr_en", wr_en, 0);
        checkOutput("init_wr_addr", wr_addr, 0);
        checkOutput("init_wr_data", wr_data, 0);
        checkOutput("init_frame_done", frame_done, 0);
        checkOutput("init_frame_ok", frame_ok, 0);
        checkOutput("init_line_err", line_err, 0);
        checkOutput("init_frame_cnt", frame_cnt, 0);
        chk_en = 1;

        // Pixels before any vsync are ignored; the first vsync is not a frame end.
        send_line(4, -1, -1);
        send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("first_vsync_cnt", frame_cnt, 0);

        dut_writes = 0;
        repeat (3) send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("clean_writes", dut_writes, 12);
        checkOutput("clean_cnt", frame_cnt, 1);
        checkOutput("clean_ok", frame_ok, 1);

        send_line(3, -1, -1);
        checkOutput("short_line_err", line_err, 1);
        send_line(5, -1, -1);
        send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("badlen_ok", frame_ok, 0);
        checkOutput("badlen_cnt", frame_cnt, 2);
        checkOutput("new_frame_line_err", line_err, 0);

        repeat (4) send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("extra_line_ok", frame_ok, 0);
        repeat (3) send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("recover_ok", frame_ok, 1);
        checkOutput("recover_cnt", frame_cnt, 4);

        send_line(4, -1, -1);
        send_line(4, 2, -1);
        checkOutput("hsync_line_err", line_err, 1);
        send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("hsync_ok", frame_ok, 0);

        send_line(4, -1, -1);
        send_line(4, -1, -1);
        send_partial(2);
        checkOutput("trunc_ok", frame_ok, 0);
        checkOutput("trunc_cnt", frame_cnt, 6);

        repeat (3) send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("pre_reset_cnt", frame_cnt, 7);

        send_line(4, -1, -1);
        send_line(4, -1, 2);
        send_line(4, -1, -1);
        send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("post_reset_cnt", frame_cnt, 0);
        repeat (3) send_line(4, -1, -1);
        vsync_pulse(0);
        checkOutput("resume_cnt", frame_cnt, 1);
        checkOutput("resume_ok", frame_ok, 1);

        repeat (4) applyStimulus(0, 1, 1, 0, '0);
        checkOutput("writes_left", wq.size(), 0);
        checkOutput("frames_left", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
